hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
Iterative multiply/divide unit that owns the HI and LO architectural registers. It sits in the EX/MEM region and drives the ReadDataHi and ReadDataLo inputs of the write-back stage, which returns HI/LO via its HiOrLo/HiToReg mux path.
- Executes MULT, MULTU, MADD, MSUB, DIV and DIVU as 33-cycle operations.
- Executes MTHI and MTLO as single-cycle writes.
- Exports Busy so the hazard unit can stall MFHI/MFLO and back-to-back HI/LO ops.

Parameters:
WIDTH, 32, operand and HI/LO width; only 32 is supported, and the parameter exists for bench readability.

Ports:
Clk  input  1  clock; all state updates on the rising edge
Rst_n  input  1  synchronous, active-low reset; sampled on the rising Clk edge
Start  input  1  operation request; accepted only when Busy=0
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
RsData  input  WIDTH  operand A (dividend/multiplicand; MTHI/MTLO source)
RtData  input  WIDTH  operand B (divisor/multiplier)
Abort  input  1  pipeline flush; cancels an in-flight op, HI/LO unchanged
Busy  output  1  high while a multi-cycle op is in flight
Done  output  1  one-cycle pulse when HI/LO take multi-cycle results
ReadDataHi  output  WIDTH  current HI register
ReadDataLo  output  WIDTH  current LO register

Behaviour:
Reset:
- Rst_n=0 at an edge: HI=0, LO=0, state=IDLE, Busy=0, Done=0, counter=0.
- Reset mid-operation discards all in-flight work.

States: IDLE, RUN, FIX.
- IDLE, Start=1, Op in {110, 111}: at the same edge, HI (MTHI) or LO (MTLO) = RsData. State stays IDLE; Busy and Done stay 0.
- IDLE, Start=1, other Op: latch operand magnitudes, the result-sign flags and Op. Counter=31, go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
  - When counter=0, go to FIX; otherwise counter decrements.
- FIX: one cycle.
  - Apply sign correction.
  - For MADD/MSUB, form {HI,LO} ± signed product as a 64-bit value, wrapping modulo 2^64.
  - Write HI/LO, go to IDLE, Done=1 for exactly the next cycle.

Timing:
- Busy is 1 in every cycle where state is RUN or FIX, so it is high for 33 cycles.
- Latency: Start accepted at edge E0; results visible and Done=1 after edge E33.

Arithmetic rules:
- MULT, MADD, MSUB: signed.
- MULTU: unsigned.
- Product: {HI,LO}.
- Divide: LO = quotient, HI = remainder.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero, signed or unsigned: LO=0xFFFFFFFF, HI=RsData.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.

Boundary conditions:
- Start while Busy=1 is ignored; the hazard unit must hold the instruction.
- ReadDataHi/ReadDataLo always reflect the committed registers. They never show partial results during RUN.
- Abort in RUN or FIX: go to IDLE at that edge, no HI/LO write, Done stays 0.
- Abort and Start in the same IDLE cycle: Abort wins, and nothing is accepted or written.
- Rst_n=0 overrides everything, including Abort and Start.

Decomposition:
- Shared header (`include): Op encodings, state encodings, ITER=32 constant.
- One natural sub-module, seq_muldiv_core. It holds the shift/accumulate datapath and the counter, and takes load/step controls from the top-level FSM.
- The top-level keeps the FSM, HI/LO registers, sign correction and the MADD/MSUB accumulation.

Test Plan:
- Reset then MTHI RsData=0x12345678, next cycle MTLO RsData=0x9ABCDEF0 -> HI=0x12345678, LO=0x9ABCDEF0 one edge after each op; Busy never rises.
- MULT RsData=0xFFFFFFFE (-2), RtData=0x00000003 -> after E33, HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulses 1 cycle; Busy high for exactly 33 cycles; HI/LO unchanged during RUN.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MADD 2 x 3 -> HI=0xFFFFFFFE, LO=0x00000007. Then MSUB 1 x 8 -> HI=0xFFFFFFFD, LO=0xFFFFFFFF.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start DIVU 100 / 7, raise a second Start at cycle 5 (ignored), Abort at cycle 10 -> Busy drops after that edge, Done never pulses, HI/LO keep their prior values. A fresh DIVU then gives LO=14, HI=2.
- Start MULT 5 x 5, drive Rst_n=0 at cycle 20 -> HI=0, LO=0, Busy=0, Done=0 after that edge, and no late Done or write follows.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide unit.
package hilo_muldiv_unit_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MSUB  = 3'b101,
    OP_MTHI  = 3'b110,
    OP_MTLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Ops whose operands are interpreted as two's complement.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// Radix-2 sequential datapath on unsigned magnitudes: shift-add multiply
// or restoring shift-subtract divide, plus the iteration counter.
module seq_muldiv_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;

  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Next-state of the datapath for one radix-2 step.
  always_comb begin
    acc_nxt = acc;
    lo_nxt  = lo_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (div_q) begin
      // Partial remainder can reach 33 bits, so the trial subtract is 34 bits
      // wide and its top bit is a clean borrow.
      shifted = {acc[WIDTH-1:0], lo_q[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, b_q};
      if (!diff[WIDTH+1]) begin
        acc_nxt = diff[WIDTH:0];
        lo_nxt  = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted;
        lo_nxt  = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = lo_q[0] ? ({1'b0, acc[WIDTH-1:0]} + {1'b0, b_q}) : {1'b0, acc[WIDTH-1:0]};
      acc_nxt = {1'b0, sum[WIDTH:1]};
      lo_nxt  = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand load, per-step update and iteration counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      count <= '0;
    end else if (load) begin
      acc   <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
      div_q <= is_div;
      count <= CNT_W'(ITER - 1);
    end else if (step) begin
      acc  <= acc_nxt;
      lo_q <= lo_nxt;
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign res_hi = acc[WIDTH-1:0];
  assign res_lo = lo_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: control FSM, architectural registers, sign correction and
// MADD/MSUB accumulation around the sequential multiply/divide core.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ReadDataHi,
  output logic [WIDTH-1:0] ReadDataLo
);

  state_e           state;
  op_e              op_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             div0_q;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  op_e              op_in;
  logic             is_mt;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             core_load;
  logic             core_step;

  logic [CNT_W-1:0] core_count;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] fix_result;

  // Request decode and operand magnitude/sign extraction.
  always_comb begin
    op_in     = op_e'(Op);
    is_mt     = (op_in == OP_MTHI) || (op_in == OP_MTLO);
    accept    = (state == ST_IDLE) && Start && !Abort;
    a_neg     = op_is_signed(op_in) && RsData[WIDTH-1];
    b_neg     = op_is_signed(op_in) && RtData[WIDTH-1];
    a_mag     = a_neg ? (~RsData + 1'b1) : RsData;
    b_mag     = b_neg ? (~RtData + 1'b1) : RtData;
    core_load = accept && !is_mt;
    core_step = (state == ST_RUN) && !Abort;
  end

  seq_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_is_div(op_in)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .count  (core_count),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // Sign correction and final HI/LO value formed in the FIX cycle.
  always_comb begin
    raw  = {core_hi, core_lo};
    prod = neg_q ? (~raw + 1'b1) : raw;
    quo  = neg_q ? (~core_lo + 1'b1) : core_lo;
    rem  = rem_neg_q ? (~core_hi + 1'b1) : core_hi;
    fix_result = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: fix_result = prod;
      OP_MADD:           fix_result = {hi_q, lo_q} + prod;
      OP_MSUB:           fix_result = {hi_q, lo_q} - prod;
      OP_DIV, OP_DIVU:   fix_result = div0_q ? {rs_q, {WIDTH{1'b1}}} : {rem, quo};
      default:           fix_result = {hi_q, lo_q};
    endcase
  end

  // Control FSM with registered Busy/Done and HI/LO commit.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      rs_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_in == OP_MTHI) begin
              hi_q <= RsData;
            end else if (op_in == OP_MTLO) begin
              lo_q <= RsData;
            end else begin
              op_q      <= op_in;
              neg_q     <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              div0_q    <= (RtData == '0);
              rs_q      <= RsData;
              state     <= ST_RUN;
              Busy      <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (Abort) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else if (core_count == '0) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
          if (!Abort) begin
            {hi_q, lo_q} <= fix_result;
            Done         <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ReadDataHi = hi_q;
  assign ReadDataLo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected {HI,LO} queued at issue,
// compared when Done pulses.
module tb_hilo_muldiv_unit;

  localparam int unsigned WIDTH = 32;

  logic             Clk;
  logic             Rst_n;
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] RsData;
  logic [WIDTH-1:0] RtData;
  logic             Abort;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ReadDataHi;
  logic [WIDTH-1:0] ReadDataLo;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;

  hilo_muldiv_unit #(
    .WIDTH(WIDTH)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Op         (Op),
    .RsData     (RsData),
    .RtData     (RtData),
    .Abort      (Abort),
    .Busy       (Busy),
    .Done       (Done),
    .ReadDataHi (ReadDataHi),
    .ReadDataLo (ReadDataLo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent reference using native 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] hilo);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return hilo + 64'(sa * sb);
      3'd5: return hilo - 64'(sa * sb);
      default: return hilo;
    endcase
  endfunction

  // Result monitor: every Done pulse must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Done) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_eq("result_hi", {32'h0, ReadDataHi}, {32'h0, e[63:32]});
        check_eq("result_lo", {32'h0, ReadDataLo}, {32'h0, e[31:0]});
      end
    end
  end

  // Single-cycle MTHI/MTLO; called and returns at a falling edge.
  task automatic mt_write(input logic [2:0] op, input logic [31:0] val);
    Op = op; RsData = val; RtData = 32'h0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    if (op == 3'b110) model_hilo[63:32] = val;
    else              model_hilo[31:0]  = val;
    check_eq("mt_hi", {32'h0, ReadDataHi}, {32'h0, model_hilo[63:32]});
    check_eq("mt_lo", {32'h0, ReadDataLo}, {32'h0, model_hilo[31:0]});
    check_eq("mt_busy", {63'h0, Busy}, 0);
  endtask

  // Multi-cycle op; called and returns at a falling edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] prev;
    int          n;
    bit          changed;
    prev = {ReadDataHi, ReadDataLo};
    Op = op; RsData = a; RtData = b; Start = 1'b1;
    exp_q.push_back(exp);
    model_hilo = exp;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    changed = 1'b0;
    while (Busy && n < 40) begin
      n++;
      if ({ReadDataHi, ReadDataLo} !== prev) changed = 1'b1;
      @(negedge Clk);
    end
    check_eq({tag, "_busy_len"}, 64'(n), 33);
    check_eq({tag, "_hold"}, {63'h0, changed}, 0);
    check_eq({tag, "_done"}, {63'h0, Done}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prev;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; Op = 3'b000; RsData = '0; RtData = '0;
    model_hilo = '0;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("reset_hi", {32'h0, ReadDataHi}, 0);
    check_eq("reset_lo", {32'h0, ReadDataLo}, 0);
    check_eq("reset_busy", {63'h0, Busy}, 0);
    check_eq("reset_done", {63'h0, Done}, 0);

    mt_write(3'b110, 32'h1234_5678);
    mt_write(3'b111, 32'h9ABC_DEF0);
    check_eq("mt_both", {ReadDataHi, ReadDataLo}, 64'h1234_5678_9ABC_DEF0);

    run_op("mult_neg",  3'b000, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("madd",      3'b100, 32'h2, 32'h3, 64'hFFFF_FFFE_0000_0007);
    run_op("msub",      3'b101, 32'h1, 32'h8, 64'hFFFF_FFFD_FFFF_FFFF);
    run_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 3'b011, 32'h7, 32'h0, 64'h0000_0007_FFFF_FFFF);
    run_op("div_zero",  3'b010, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF);
    run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

    // Abort mid-run with an ignored Start while busy.
    prev = model_hilo;
    Op = 3'b011; RsData = 32'd100; RtData = 32'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Op = 3'b000; RsData = 32'd9; RtData = 32'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    check_eq("abort_pre_busy", {63'h0, Busy}, 1);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check_eq("abort_busy", {63'h0, Busy}, 0);
    check_eq("abort_done", {63'h0, Done}, 0);
    check_eq("abort_hilo", {ReadDataHi, ReadDataLo}, prev);

    // Abort beats Start in IDLE.
    Op = 3'b110; RsData = 32'hDEAD_BEEF; Start = 1'b1; Abort = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    check_eq("abort_start_hilo", {ReadDataHi, ReadDataLo}, prev);
    check_eq("abort_start_busy", {63'h0, Busy}, 0);
    repeat (40) @(negedge Clk);
    check_eq("abort_late_hilo", {ReadDataHi, ReadDataLo}, prev);

    run_op("divu_fresh", 3'b011, 32'd100, 32'd7, {32'd2, 32'd14});

    // Reset in the middle of a multiply.
    Op = 3'b000; RsData = 32'd5; RtData = 32'd5; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (19) @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    model_hilo = '0;
    check_eq("rst_mid_hilo", {ReadDataHi, ReadDataLo}, 0);
    check_eq("rst_mid_busy", {63'h0, Busy}, 0);
    check_eq("rst_mid_done", {63'h0, Done}, 0);
    repeat (40) @(negedge Clk);
    check_eq("rst_late_hilo", {ReadDataHi, ReadDataLo}, 0);
    check_eq("rst_late_busy", {63'h0, Busy}, 0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op("rand", rop, ra, rb, ref_model(rop, ra, rb, model_hilo));
    end

    @(negedge Clk);
    check_eq("queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
